// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT bit-reverse reorder buffer: defaults, read FSM states,
// and helpers for index bit reversal and saturating negation.
package fft_defs;

  localparam int DEF_N_LOG2 = 6;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

  // Reverse the low n bits of k (n <= 12); upper bits of the result are zero.
  function automatic logic [11:0] bitrev(input logic [11:0] k, input int n);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      if (i < n) r[4'(i)] = k[4'(n - 1 - i)];
    end
    return r;
  endfunction

  // Negate a sign-extended w-bit value; the most negative code saturates to max positive.
  function automatic logic [63:0] sat_neg(input logic [63:0] v, input int w);
    logic [63:0] min_v;
    min_v = ~64'd0 << (w - 1);
    if (v == min_v) return (64'd1 << (w - 1)) - 64'd1;
    return -v;
  endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// Sample stream bundle for fft_reorder: bit-reversed input side and natural-order output side.
// master drives samples in and observes results; slave is the reorder block.
interface fft_reorder_if #(
  parameter int DATA_W = fft_defs::DEF_DATA_W
);
  logic              inv;
  logic              valid_in;
  logic              sop_in;
  logic [DATA_W-1:0] x_re;
  logic [DATA_W-1:0] x_im;
  logic              valid_out;
  logic              sop_out;
  logic              inv_out;
  logic              err_out;
  logic [DATA_W-1:0] y_re;
  logic [DATA_W-1:0] y_im;

  modport master (
    output inv, valid_in, sop_in, x_re, x_im,
    input  valid_out, sop_out, inv_out, err_out, y_re, y_im
  );

  modport slave (
    input  inv, valid_in, sop_in, x_re, x_im,
    output valid_out, sop_out, inv_out, err_out, y_re, y_im
  );
endinterface

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: simple dual-port RAM, 2**AW x DW, registered read.
// Read data appears one edge after re; rdata holds while re is low. No backpressure.
module fft_reorder_bank #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1 << AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order frame reorder using two ping-pong banks; output N cycles per frame,
// first output 2 edges after the last input (3 with FFT_REORDER_CONJ_EN). No backpressure.
module fft_reorder
  import fft_defs::*;
#(
  parameter int N_LOG2 = DEF_N_LOG2,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  fft_reorder_if.slave io
);
  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  // write side
  logic              wr_bank;
  logic [N_LOG2-1:0] wr_idx;
  logic              frame_open;
  logic              cur_inv;
  logic              wr_en, wr_done, err_nxt;
  logic [N_LOG2-1:0] wr_k, wr_addr;

  // bank state
  logic [1:0] full;
  logic [1:0] bank_inv;

  // read side
  rd_state_t         rd_state, rd_state_nxt;
  logic [N_LOG2-1:0] rd_idx, rd_idx_nxt;
  logic              rd_bank, rd_bank_nxt;
  logic              rd_en, rd_last;
  logic [2*DATA_W-1:0] rd_dat [2];

  // pipeline
  logic              s1_vld, s1_sop, s1_inv, s1_bank;
  logic [DATA_W-1:0] s1_re, s1_im;
  logic              s2_vld, s2_sop, s2_inv;
  logic [DATA_W-1:0] s2_re, s2_im;

  always_comb begin
    wr_en   = 1'b0;
    wr_done = 1'b0;
    err_nxt = 1'b0;
    wr_k    = wr_idx;
    if (io.valid_in) begin
      if (io.sop_in) begin
        // a sop while a frame is open discards the partial frame
        wr_en   = 1'b1;
        wr_k    = '0;
        err_nxt = frame_open;
      end else if (frame_open) begin
        wr_en   = 1'b1;
        wr_done = (wr_idx == LAST);
      end else begin
        err_nxt = 1'b1;
      end
    end
    wr_addr = N_LOG2'(bitrev(12'(wr_k), N_LOG2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      frame_open <= 1'b0;
      cur_inv    <= 1'b0;
      io.err_out <= 1'b0;
    end else begin
      io.err_out <= err_nxt;
      if (wr_en) begin
        if (io.sop_in) cur_inv <= io.inv;
        if (wr_done) begin
          wr_idx     <= '0;
          frame_open <= 1'b0;
          wr_bank    <= ~wr_bank;
        end else begin
          wr_idx     <= wr_k + 1'b1;
          frame_open <= 1'b1;
        end
      end
    end
  end

  // Fill and drain never target the same bank at once, so set/clear cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= '0;
      bank_inv <= '0;
    end else begin
      if (wr_done) begin
        full[wr_bank]     <= 1'b1;
        bank_inv[wr_bank] <= cur_inv;
      end
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_idx   <= '0;
      rd_bank  <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_idx   <= rd_idx_nxt;
      rd_bank  <= rd_bank_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_idx_nxt   = rd_idx;
    rd_bank_nxt  = rd_bank;
    rd_en        = 1'b0;
    rd_last      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        if (full[rd_bank]) begin
          rd_en        = 1'b1;
          rd_idx_nxt   = N_LOG2'(1);
          rd_state_nxt = RD_BUSY;
        end
      end
      RD_BUSY: begin
        rd_en = 1'b1;
        if (rd_idx == LAST) begin
          rd_last      = 1'b1;
          rd_idx_nxt   = '0;
          rd_bank_nxt  = ~rd_bank;
          rd_state_nxt = RD_IDLE;
        end else begin
          rd_idx_nxt = rd_idx + 1'b1;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(
      .AW(N_LOG2),
      .DW(2 * DATA_W)
    ) u_bank (
      .clk  (clk),
      .we   (wr_en && (wr_bank == 1'(b))),
      .waddr(wr_addr),
      .wdata({io.x_re, io.x_im}),
      .re   (rd_en && (rd_bank == 1'(b))),
      .raddr(rd_idx),
      .rdata(rd_dat[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sop  <= 1'b0;
      s1_inv  <= 1'b0;
      s1_bank <= 1'b0;
    end else begin
      s1_vld  <= rd_en;
      s1_sop  <= rd_en && (rd_state == RD_IDLE);
      s1_inv  <= bank_inv[rd_bank];
      s1_bank <= rd_bank;
    end
  end

  assign {s1_re, s1_im} = rd_dat[s1_bank];

`ifdef FFT_REORDER_CONJ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld <= 1'b0;
      s2_sop <= 1'b0;
      s2_inv <= 1'b0;
      s2_re  <= '0;
      s2_im  <= '0;
    end else begin
      s2_vld <= s1_vld;
      s2_sop <= s1_sop;
      s2_inv <= s1_inv;
      s2_re  <= s1_re;
      s2_im  <= s1_inv ? DATA_W'(sat_neg(64'(signed'(s1_im)), DATA_W)) : s1_im;
    end
  end
`else
  always_comb begin
    s2_vld = s1_vld;
    s2_sop = s1_sop;
    s2_inv = s1_inv;
    s2_re  = s1_re;
    s2_im  = s1_im;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.valid_out <= 1'b0;
      io.sop_out   <= 1'b0;
      io.inv_out   <= 1'b0;
      io.y_re      <= '0;
      io.y_im      <= '0;
    end else begin
      io.valid_out <= s2_vld;
      io.sop_out   <= s2_vld && s2_sop;
      if (s2_vld) begin
        io.inv_out <= s2_inv;
        io.y_re    <= s2_re;
        io.y_im    <= s2_im;
      end
    end
  end
endmodule

// File: tb/tb_fft_reorder.sv
// Scoreboard bench for fft_reorder (N_LOG2=6, DATA_W=16): table of frame scenarios plus
// hand-written reset sequences; expected samples are queued when the last input is driven.
module tb_fft_reorder;
`ifdef FFT_REORDER_CONJ_EN
  localparam int LAT  = 3;
  localparam bit CONJ = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit CONJ = 1'b0;
`endif

  typedef struct {
    logic        sop;
    logic        inv;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  typedef struct {
    string name;
    bit    inv;
    bit    ramp;
    int    gap_pct;
    int    abort_k;
    int    nfr;
    int    exp_err;
    int    exp_run;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   err_cnt = 0;
  int   run = 0;
  int   last_run = 0;
  int   sop_cyc = 0;
  int   last_cyc = 0;
  exp_t q[$];

  fft_reorder_if #(.DATA_W(16)) io();

  fft_reorder #(.N_LOG2(6), .DATA_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int br6(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if (((k >> i) & 1) != 0) r |= 1 << (5 - i);
    return r;
  endfunction

  function automatic logic [15:0] neg16(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return 16'(0 - int'(signed'(v)));
  endfunction

  // output monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run = 0;
    end else begin
      if (io.err_out) err_cnt++;
      if (io.valid_out) begin
        run++;
        if (io.sop_out) sop_cyc = cyc;
        if (q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sop_out", io.sop_out, e.sop);
          check("inv_out", io.inv_out, e.inv);
          check("y_re", io.y_re, e.re);
          check("y_im", io.y_im, e.im);
        end
      end else if (run != 0) begin
        last_run = run;
        check("contiguous", run % 64, 0);
        run = 0;
      end
    end
  end

  task automatic drive_idle();
    io.valid_in = 1'b0;
    io.sop_in   = 1'b0;
  endtask

  task automatic send_partial(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      io.valid_in = 1'b1;
      io.sop_in   = (k == 0);
      io.inv      = 1'b0;
      io.x_re     = 16'($urandom);
      io.x_im     = 16'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input bit inv, input bit ramp, input int gap_pct);
    logic [15:0] dre[64];
    logic [15:0] dim[64];
    exp_t e;
    int n;
    for (int i = 0; i < 64; i++) begin
      dre[i] = ramp ? 16'(i) : 16'($urandom);
      dim[i] = ramp ? 16'h0000 : 16'($urandom);
    end
    if (inv) begin
      dim[0] = 16'h8000;
      dim[1] = 16'h0005;
      dim[2] = 16'h7FFF;
    end
    for (int k = 0; k < 64; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        drive_idle();
        @(negedge clk);
      end
      n = br6(k);
      if (k == 63) begin
        last_cyc = cyc;
        for (int i = 0; i < 64; i++) begin
          e.sop = (i == 0);
          e.inv = inv;
          e.re  = dre[i];
          e.im  = (inv && CONJ) ? neg16(dim[i]) : dim[i];
          q.push_back(e);
        end
      end
      io.valid_in = 1'b1;
      io.sop_in   = (k == 0);
      io.inv      = inv;
      io.x_re     = dre[n];
      io.x_im     = dim[n];
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check(name, q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid_out"}, io.valid_out, 0);
    check({tag, "_sop_out"}, io.sop_out, 0);
    check({tag, "_inv_out"}, io.inv_out, 0);
    check({tag, "_err_out"}, io.err_out, 0);
    check({tag, "_y_re"}, io.y_re, 0);
    check({tag, "_y_im"}, io.y_im, 0);
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{"single",  1'b0, 1'b1, 0,  -1, 1, 0, 64};
    vecs[1] = '{"b2b3",    1'b0, 1'b0, 0,  -1, 3, 0, 192};
    vecs[2] = '{"gaps",    1'b0, 1'b0, 30, -1, 1, 0, 64};
    vecs[3] = '{"abort20", 1'b0, 1'b0, 0,  20, 1, 1, 64};
    vecs[4] = '{"inv",     1'b1, 1'b0, 0,  -1, 1, 0, 64};

    io.inv = 1'b0; io.x_re = '0; io.x_im = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // stray sample with no frame open right after reset
    io.valid_in = 1'b1;
    io.sop_in   = 1'b0;
    io.x_re     = 16'h1234;
    @(negedge clk);
    drive_idle();
    repeat (10) @(negedge clk);
    check("drop_err_cnt", err_cnt, 1);
    check("drop_valid_out", io.valid_out, 0);

    foreach (vecs[v]) begin
      err_cnt = 0;
      if (vecs[v].abort_k >= 0) send_partial(vecs[v].abort_k);
      for (int f = 0; f < vecs[v].nfr; f++) send_frame(vecs[v].inv, vecs[v].ramp, vecs[v].gap_pct);
      drain({vecs[v].name, "_drain"});
      check({vecs[v].name, "_latency"}, sop_cyc, last_cyc + 1 + LAT);
      check({vecs[v].name, "_err_cnt"}, err_cnt, vecs[v].exp_err);
      check({vecs[v].name, "_run_len"}, last_run, vecs[v].exp_run);
    end

    // reset in the middle of an output frame
    send_frame(1'b1, 1'b0, 0);
    for (int i = 0; i < 300 && !io.valid_out; i++) @(negedge clk);
    check("midrst_saw_output", io.valid_out, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_quiet", io.valid_out, 0);

    // normal operation resumes with a fresh sop after reset
    err_cnt = 0;
    send_frame(1'b0, 1'b1, 0);
    drain("post_rst_drain");
    check("post_rst_latency", sop_cyc, last_cyc + 1 + LAT);
    check("post_rst_err_cnt", err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter N_LOG2, default 6, log2 of frame length N (legal 2..12).
REQ-002 Parameter DATA_W, default 16, width of each real/imag component, two's complement.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 inv  in  1  frame mode (1 = inverse transform), sampled with sop_in.
REQ-006 valid_in  in  1  input sample qualifier.
REQ-007 sop_in  in  1  first sample of frame, qualified by valid_in.
REQ-008 x_re, x_im  in  DATA_W each  input sample, bit-reversed order (radix-2 DIF FFT output).
REQ-009 valid_out  out  1  output sample qualifier.
REQ-010 sop_out  out  1  first sample of output frame.
REQ-011 inv_out  out  1  inv latched for the frame being output; held for the whole frame.
REQ-012 err_out  out  1  one-cycle pulse on protocol error.
REQ-013 y_re, y_im  out  DATA_W each  output sample, natural order.

Function
REQ-014 The block SHALL reorder each N-sample frame from bit-reversed to natural order using two ping-pong banks of N entries.
REQ-015 Accepted sample k (k = 0..N-1 counted from sop_in) SHALL be written to the write bank at address bitrev(k, N_LOG2).
REQ-016 valid_in low SHALL pause the write index; gaps of any length are legal.
REQ-017 On the sample with k = N-1, the write bank SHALL become full, and the write side SHALL switch to the other bank.
REQ-018 A full bank SHALL be read at addresses 0..N-1, one per cycle, with no gaps and no backpressure.
REQ-019 Latency: if the last input sample is accepted at edge t, then valid_out=1 and sop_out=1 SHALL appear after edge t+2.
REQ-020 valid_out SHALL then stay high for exactly N cycles; sop_out SHALL be high only on the first of them.
REQ-021 Back-to-back frames with no valid_in gaps SHALL produce back-to-back output frames with no gap; overrun is impossible by construction.
REQ-022 sop_in during a partial frame SHALL discard the partial frame, restart at k=0 in the same bank, and pulse err_out.
REQ-023 valid_in without sop_in while no frame is open (after reset or after k=N-1) SHALL drop the sample and pulse err_out.
REQ-024 sop_in arriving on the same edge a frame completes SHALL open the next frame normally, with no error.
REQ-025 Outputs SHALL come from registers; y_re/y_im SHALL hold their last value when valid_out=0.

Reset
REQ-026 On rst: valid_out, sop_out, inv_out, err_out = 0; y_re, y_im = 0; write index = 0; no frame open; both banks empty; write bank = 0.
REQ-027 rst mid-frame or mid-output SHALL abort all frames; bank RAM contents need not be cleared.
REQ-028 The first sample accepted after rst deassertion SHALL be one with sop_in=1.

Configuration
REQ-029 Macro FFT_REORDER_CONJ_EN, when defined: for frames with inv_out=1, y_im SHALL be -x_im, saturated so that -2^(DATA_W-1) maps to 2^(DATA_W-1)-1; the output stage gains one register, so the REQ-019 latency becomes t+3.
REQ-030 Without FFT_REORDER_CONJ_EN: data SHALL pass unchanged, latency SHALL be t+2, and inv_out SHALL be informational only.

Structure
REQ-031 Shared package fft_defs SHALL hold the bitrev function, default N_LOG2 and DATA_W, and the saturating negate function.
REQ-032 One sub-module, fft_reorder_bank, SHALL be used: a simple dual-port RAM, N x 2*DATA_W, synchronous read, instantiated twice.
REQ-033 Write control, read control and bank-state flags SHALL stay in fft_reorder.

Verification (N_LOG2=6, DATA_W=16)
REQ-034 One frame, x_re = bitrev(k), x_im = 0, inv=0 -> 64 outputs with y_re = 0..63 in order, sop_out on the first, first valid_out 2 cycles after the last input.
REQ-035 Three frames back-to-back, no gaps -> 192 contiguous valid_out cycles, sop_out at offsets 0, 64, 128, data correct per frame.
REQ-036 Frame with random valid_in gaps (about 30% idle) -> same output as the gap-free frame; output frame contiguous.
REQ-037 sop_in at k=20, then a full frame -> one err_out pulse; only the second frame is output.
REQ-038 valid_in=1, sop_in=0 immediately after reset -> sample dropped, err_out pulse, valid_out stays 0.
REQ-039 With FFT_REORDER_CONJ_EN and inv=1, x_im = 16'h8000 and 16'h0005 -> y_im = 16'h7FFF and 16'hFFFB, inv_out=1 for all 64 outputs; rst asserted mid-output -> all outputs 0 immediately.
